// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the MEM-stage data-memory responder.
package dmem_pkg;

  // MemSize encodings as produced by instruction decode.
  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_BAD  = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Wait-state counter width; covers WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: MEM-stage request/response bundle between the pipeline
// (master) and the data-memory responder (slave).
interface dmem_access_unit_if;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemSign;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Valid;
  logic        Stall;
  logic        AccessErr;

  modport master (
    output MemRead, MemWrite, MemSize, MemSign, Address, WriteData,
    input  ReadData, Valid, Stall, AccessErr
  );

  modport slave (
    input  MemRead, MemWrite, MemSize, MemSign, Address, WriteData,
    output ReadData, Valid, Stall, AccessErr
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian lane steering for stores and lane extraction
// with sign/zero extension for loads. Purely combinational.
// Build macro DMEM_ALIGN_CHECK_EN: when defined, misaligned half/word accesses
// raise misalign; otherwise the low address bits are ignored for them.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [31:0] rsh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Decode lane enables, replicate store data across lanes, extract and extend the load lane.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave a latch behind.
    be       = 4'b0000;
    wdata_sh = wdata;
    rdata    = '0;
    misalign = 1'b0;
    rsh      = rword >> {addr, 3'b000};
    lane_b   = rsh[7:0];
    lane_h   = addr[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: begin
        be       = 4'b0001 << addr;
        wdata_sh = {4{wdata[7:0]}};
        rdata    = {{24{sign & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
        rdata    = {{16{sign & lane_h[15]}}, lane_h};
`ifdef DMEM_ALIGN_CHECK_EN
        misalign = addr[0];
`endif
      end
      SZ_WORD: begin
        be    = 4'b1111;
        rdata = rword;
`ifdef DMEM_ALIGN_CHECK_EN
        misalign = (addr != 2'b00);
`endif
      end
      default: begin
        be    = 4'b0000;
        rdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage data-memory responder. Word-organised array with
// byte/half/word access, programmable wait states (Stall) and a registered
// load result for the MEM/WB boundary.
// Build macro DMEM_ALIGN_CHECK_EN: reject misaligned half/word accesses.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input logic               Clk,
  input logic               Reset_n,
  dmem_access_unit_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  logic [31:0]      mem [DEPTH_WORDS];
  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             req, commit, stall_raw, reject, misalign, wr_en;
  logic [AW-1:0]    index;
  logic [3:0]       be;
  logic [31:0]      wdata_sh, rdata_ext, rword, read_data_q;
  logic             valid_q, err_q;
  logic             addr_unused;

  assign req         = bus.MemRead | bus.MemWrite;
  // Upper address bits fall off the top so accesses wrap modulo the array.
  assign index       = bus.Address[AW+1:2];
  assign addr_unused = ^bus.Address[31:AW+2];
  assign rword       = mem[index];

  dmem_lane_align u_align (
    .size     (bus.MemSize),
    .addr     (bus.Address[1:0]),
    .sign     (bus.MemSign),
    .wdata    (bus.WriteData),
    .rword    (rword),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (rdata_ext),
    .misalign (misalign)
  );

  assign reject = (bus.MemRead & bus.MemWrite) | (bus.MemSize == SZ_BAD) | misalign;
  // A commit seen while reset is low must not touch the array.
  assign wr_en  = commit & ~reject & bus.MemWrite & Reset_n;

  // State and wait counter register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state, wait-state countdown, commit strobe and raw stall.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    commit    = 1'b0;
    stall_raw = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            commit = 1'b1;
          end else begin
            stall_raw = 1'b1;
            state_nx  = ST_WAIT;
            cnt_nx    = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          // Request withdrawn (pipeline flush): abandon without committing.
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (cnt != '0) begin
          stall_raw = 1'b1;
          cnt_nx    = cnt - 1'b1;
        end else begin
          commit   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign bus.Stall = stall_raw & Reset_n;

  // Registered response: load data with Valid, or AccessErr with zeroed data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_data_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (commit) begin
        if (reject) begin
          err_q       <= 1'b1;
          read_data_q <= '0;
        end else if (bus.MemRead) begin
          valid_q     <= 1'b1;
          read_data_q <= rdata_ext;
        end
      end
    end
  end

  // Lane-masked array write.
  always_ff @(posedge Clk) begin
    // NOTE: the array has no reset; clearing it would force flops instead of RAM.
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[index][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign bus.ReadData  = read_data_q;
  assign bus.Valid     = valid_q;
  assign bus.AccessErr = err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: two instances (no wait states, three wait states) checked
// every cycle against a byte-array model, plus literal spot checks.
module tb_dmem_access_unit;
  import dmem_pkg::*;

  localparam int DEPTH  = 64;
  localparam int NBYTES = DEPTH * 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  dmem_access_unit_if bus0 ();
  dmem_access_unit_if bus3 ();

  dmem_access_unit #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u0 (
    .Clk(clk), .Reset_n(rst_n), .bus(bus0)
  );
  dmem_access_unit #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u3 (
    .Clk(clk), .Reset_n(rst_n), .bus(bus3)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          wait_of [2] = '{0, 3};
  logic [7:0]  mb [2][NBYTES];
  int          held [2] = '{0, 0};
  logic        exp_valid [2] = '{1'b0, 1'b0};
  logic        exp_err [2] = '{1'b0, 1'b0};
  logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of one instance: a request held for W prior cycles commits now.
  task automatic model_edge(input int k, input logic rd, input logic wr, input logic [1:0] sz,
                            input logic sg, input logic [31:0] a, input logic [31:0] wd);
    logic        err;
    int          base, n;
    logic [31:0] val;
    exp_valid[k] = 1'b0;
    exp_err[k]   = 1'b0;
    if (!(rd || wr)) begin
      held[k] = 0;
      return;
    end
    if (held[k] < wait_of[k]) begin
      held[k]++;
      return;
    end
    held[k] = 0;
    n    = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    base = int'(a % 32'(NBYTES));
    base = base - (base % n);
    err  = (rd && wr) || (sz == 2'd3);
`ifdef DMEM_ALIGN_CHECK_EN
    err = err || ((int'(a[1:0]) % n) != 0);
`endif
    if (err) begin
      exp_err[k]   = 1'b1;
      exp_rdata[k] = '0;
    end else if (wr) begin
      for (int i = 0; i < n; i++) mb[k][base+i] = wd[8*i +: 8];
    end else begin
      val = '0;
      for (int i = 0; i < n; i++) val[8*i +: 8] = mb[k][base+i];
      if (sg && n < 4 && val[8*n-1])
        for (int i = n; i < 4; i++) val[8*i +: 8] = 8'hFF;
      exp_rdata[k] = val;
      exp_valid[k] = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        held[k] = 0; exp_valid[k] = 1'b0; exp_err[k] = 1'b0; exp_rdata[k] = '0;
      end
    end else begin
      model_edge(0, bus0.MemRead, bus0.MemWrite, bus0.MemSize, bus0.MemSign, bus0.Address, bus0.WriteData);
      model_edge(1, bus3.MemRead, bus3.MemWrite, bus3.MemSize, bus3.MemSign, bus3.Address, bus3.WriteData);
    end
  end

  function automatic logic exp_stall(input int k, input logic req);
    return rst_n && req && (held[k] < wait_of[k]);
  endfunction

  // Per-cycle comparison, mid-cycle, for both instances.
  always @(negedge clk) begin
    check("u0_stall", 32'(bus0.Stall), 32'(exp_stall(0, bus0.MemRead | bus0.MemWrite)));
    check("u0_valid", 32'(bus0.Valid), 32'(exp_valid[0]));
    check("u0_err", 32'(bus0.AccessErr), 32'(exp_err[0]));
    check("u0_rdata", bus0.ReadData, exp_rdata[0]);
    check("u3_stall", 32'(bus3.Stall), 32'(exp_stall(1, bus3.MemRead | bus3.MemWrite)));
    check("u3_valid", 32'(bus3.Valid), 32'(exp_valid[1]));
    check("u3_err", 32'(bus3.AccessErr), 32'(exp_err[1]));
    check("u3_rdata", bus3.ReadData, exp_rdata[1]);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int k, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd);
    if (k == 0) begin
      bus0.MemRead = rd; bus0.MemWrite = wr; bus0.MemSize = sz;
      bus0.MemSign = sg; bus0.Address = a;  bus0.WriteData = wd;
    end else begin
      bus3.MemRead = rd; bus3.MemWrite = wr; bus3.MemSize = sz;
      bus3.MemSign = sg; bus3.Address = a;  bus3.WriteData = wd;
    end
  endtask

  task automatic idle(input int k);
    drive(k, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  // Hold a request for 'hold' cycles; returns 1 time unit after the last edge.
  task automatic acc(input int k, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a, input logic [31:0] wd, input int hold);
    drive(k, rd, wr, sz, sg, a, wd);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    idle(k);
  endtask

  task automatic rand_req(output logic rd, output logic wr, output logic [1:0] sz);
    int r;
    r  = $urandom_range(0, 9);
    rd = (r == 1) || (r >= 2 && r <= 5);
    wr = (r == 1) || (r >= 6);
    sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       rd, wr;
    logic [1:0] sz;
    idle(0);
    idle(1);
    #1 rst_n = 1'b0;
    bus3.MemRead = 1'b1;   // request during reset must not raise Stall
    #2;
    check("rst_rdata", bus0.ReadData, 32'h0);
    check("rst_valid", 32'(bus0.Valid), 32'h0);
    check("rst_err", 32'(bus0.AccessErr), 32'h0);
    check("rst_stall", 32'(bus3.Stall), 32'h0);
    @(posedge clk); #1;
    idle(1);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- no-wait instance: directed ----
    acc(0, 0, 1, SZ_WORD, 0, 32'h10, 32'h8899AABB, 1);
    check("sw_novalid", 32'(bus0.Valid), 32'h0);
    drive(0, 1, 0, SZ_WORD, 0, 32'h10, 32'h0);
    #2 check("lw_stall", 32'(bus0.Stall), 32'h0);
    @(posedge clk); #1; idle(0);
    check("lw_valid", 32'(bus0.Valid), 32'h1);
    check("lw_rdata", bus0.ReadData, 32'h8899AABB);
    acc(0, 1, 0, SZ_BYTE, 1, 32'h13, 32'h0, 1);
    check("lb_13", bus0.ReadData, 32'hFFFFFF88);
    acc(0, 1, 0, SZ_BYTE, 0, 32'h13, 32'h0, 1);
    check("lbu_13", bus0.ReadData, 32'h00000088);
    acc(0, 1, 0, SZ_HALF, 1, 32'h10, 32'h0, 1);
    check("lh_10", bus0.ReadData, 32'hFFFFAABB);
    acc(0, 0, 1, SZ_BYTE, 0, 32'h11, 32'h0000005A, 1);
    acc(0, 1, 0, SZ_WORD, 0, 32'h10, 32'h0, 1);
    check("sb_11", bus0.ReadData, 32'h88995ABB);
    acc(0, 0, 1, SZ_HALF, 0, 32'h12, 32'h00001234, 1);
    acc(0, 1, 0, SZ_WORD, 0, 32'h10, 32'h0, 1);
    check("sh_12", bus0.ReadData, 32'h12345ABB);
    acc(0, 1, 0, SZ_WORD, 0, 32'h12, 32'h0, 1);
`ifdef DMEM_ALIGN_CHECK_EN
    check("lw_12_err", 32'(bus0.AccessErr), 32'h1);
    check("lw_12_rdata", bus0.ReadData, 32'h0);
`else
    check("lw_12_err", 32'(bus0.AccessErr), 32'h0);
    check("lw_12_rdata", bus0.ReadData, 32'h12345ABB);
`endif
    acc(0, 1, 1, SZ_WORD, 0, 32'h10, 32'hFFFFFFFF, 1);
    check("dual_err", 32'(bus0.AccessErr), 32'h1);
    check("dual_valid", 32'(bus0.Valid), 32'h0);
    acc(0, 0, 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 1);
    check("sz11_err", 32'(bus0.AccessErr), 32'h1);
    acc(0, 1, 0, SZ_WORD, 0, 32'h110, 32'h0, 1);
    check("wrap_rd", bus0.ReadData, 32'h12345ABB);
    acc(0, 0, 1, SZ_WORD, 0, 32'hFFFFFF14, 32'hA5A55A5A, 1);
    acc(0, 1, 0, SZ_WORD, 0, 32'h14, 32'h0, 1);
    check("wrap_wr", bus0.ReadData, 32'hA5A55A5A);

    // ---- no-wait instance: preload then random ----
    for (int w = 0; w < DEPTH; w++) acc(0, 0, 1, SZ_WORD, 0, 32'(4 * w), $urandom, 1);
    for (int i = 0; i < 400; i++) begin
      rand_req(rd, wr, sz);
      acc(0, rd, wr, sz, 1'($urandom), $urandom, $urandom, 1);
    end

    // ---- three-wait instance: preload ----
    for (int w = 0; w < DEPTH; w++) acc(1, 0, 1, SZ_WORD, 0, 32'(4 * w), $urandom, 4);
    acc(1, 0, 1, SZ_WORD, 0, 32'h40, 32'h0BADF00D, 4);
    acc(1, 0, 1, SZ_WORD, 0, 32'h20, 32'hCAFEF00D, 4);

    // lw held 4 cycles: Stall 1,1,1,0 then Valid
    drive(1, 1, 0, SZ_WORD, 0, 32'h40, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("w3_stall_seq", 32'(bus3.Stall), (c < 3) ? 32'h1 : 32'h0);
      @(posedge clk); #1;
    end
    idle(1);
    check("w3_valid", 32'(bus3.Valid), 32'h1);
    check("w3_rdata", bus3.ReadData, 32'h0BADF00D);

    // flush: request dropped in the 2nd cycle
    acc(1, 1, 0, SZ_WORD, 0, 32'h40, 32'h0, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("flush_valid", 32'(bus3.Valid), 32'h0);
      check("flush_err", 32'(bus3.AccessErr), 32'h0);
    end
    @(posedge clk); #1;
    acc(1, 1, 0, SZ_WORD, 0, 32'h40, 32'h0, 4);
    check("after_flush", 32'(bus3.Valid), 32'h1);

    // reset mid-WAIT of a store
    drive(1, 0, 1, SZ_WORD, 0, 32'h20, 32'hDEADBEEF);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rstw_rdata", bus3.ReadData, 32'h0);
    check("rstw_stall", 32'(bus3.Stall), 32'h0);
    check("rstw_valid", 32'(bus3.Valid), 32'h0);
    @(posedge clk); #1;
    idle(1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    acc(1, 1, 0, SZ_WORD, 0, 32'h20, 32'h0, 4);
    check("rstw_keep", bus3.ReadData, 32'hCAFEF00D);

    // ---- three-wait instance: random hold lengths incl. flushes ----
    for (int i = 0; i < 80; i++) begin
      rand_req(rd, wr, sz);
      acc(1, rd, wr, sz, 1'($urandom), $urandom, $urandom, $urandom_range(1, 9));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
